// File: rtl/rnd_clk_sched.sv
// Random-period clock sequencer: emits bursts of o_rnd_clk cycles whose high and
// low phase lengths come from an 8-bit LFSR, with start/stop control and a cycle count.
module rnd_clk_sched #(
    parameter int          PHASE_W  = 3,
    parameter int          CNT_W    = 16,
    parameter logic [7:0]  DEF_SEED = 8'h01
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [7:0]       i_seed,
    input  logic [CNT_W-1:0] i_num_cycles,
    input  logic [3:0]       i_min_phase,
    output logic             o_rnd_clk,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [7:0]       o_lfsr
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_LOW  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             rnd_q, rnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [4:0]       ph_q, ph_d;
    logic             stop_q, stop_d;
    logic [7:0]       seed_q, seed_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [3:0]       min_q, min_d;

    logic [7:0]       lfsr_cur;
    logic [7:0]       lfsr_step;
    logic [4:0]       len_m1;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_cycle;

    // In LOAD the first HIGH phase is drawn straight from the latched seed.
    assign lfsr_cur   = (state_q == S_LOAD) ? seed_q : lfsr_q;
    assign lfsr_step  = {lfsr_cur[6:0], lfsr_cur[7] ^ lfsr_cur[5] ^ lfsr_cur[4] ^ lfsr_cur[3]};
    assign len_m1     = {1'b0, min_q} + 5'(lfsr_cur[PHASE_W-1:0]) - 5'd1;
    assign cnt_inc    = cnt_q + 1'b1;
    assign last_cycle = ((num_q != '0) && (cnt_inc == num_q)) || stop_q || i_stop;

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        ph_d    = ph_q;
        stop_d  = stop_q;
        seed_d  = seed_q;
        num_d   = num_q;
        min_d   = min_q;

        if (state_q != S_IDLE && i_stop) begin
            stop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                rnd_d = 1'b0;
                if (i_start) begin
                    seed_d  = (i_seed == 8'h00) ? DEF_SEED : i_seed;
                    num_d   = i_num_cycles;
                    min_d   = (i_min_phase == 4'd0) ? 4'd1 : i_min_phase;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_HIGH;
                rnd_d   = 1'b1;
                ph_d    = len_m1;
                lfsr_d  = lfsr_step;
            end
            S_HIGH: begin
                if (ph_q == 5'd0) begin
                    state_d = S_LOW;
                    rnd_d   = 1'b0;
                    ph_d    = len_m1;
                    lfsr_d  = lfsr_step;
                end else begin
                    ph_d = ph_q - 5'd1;
                end
            end
            S_LOW: begin
                if (ph_q == 5'd0) begin
                    cnt_d = cnt_inc;
                    if (last_cycle) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HIGH;
                        rnd_d   = 1'b1;
                        ph_d    = len_m1;
                        lfsr_d  = lfsr_step;
                    end
                end else begin
                    ph_d = ph_q - 5'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stop_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                rnd_d   = 1'b0;
                stop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            rnd_q   <= 1'b0;
            cnt_q   <= '0;
            lfsr_q  <= 8'h01;
            ph_q    <= 5'd0;
            stop_q  <= 1'b0;
            seed_q  <= DEF_SEED;
            num_q   <= '0;
            min_q   <= 4'd1;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            ph_q    <= ph_d;
            stop_q  <= stop_d;
            seed_q  <= seed_d;
            num_q   <= num_d;
            min_q   <= min_d;
        end
    end

    assign o_rnd_clk   = rnd_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_cycle_cnt = cnt_q;
    assign o_lfsr      = lfsr_q;

endmodule

// File: tb/tb_rnd_clk_sched.sv
// Checks rnd_clk_sched cycle by cycle against a phase-list model of each burst.
module tb_rnd_clk_sched;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_start;
    logic        i_stop;
    logic [7:0]  i_seed;
    logic [15:0] i_num_cycles;
    logic [3:0]  i_min_phase;
    logic        o_rnd_clk;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_cycle_cnt;
    logic [7:0]  o_lfsr;

    rnd_clk_sched dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_seed       (i_seed),
        .i_num_cycles (i_num_cycles),
        .i_min_phase  (i_min_phase),
        .o_rnd_clk    (o_rnd_clk),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cycle_cnt  (o_cycle_cnt),
        .o_lfsr       (o_lfsr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        clk;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
        logic [7:0]  lfsr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_lfsr;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] step8(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // Period index (edge count after start) lying in the middle of the k-th HIGH phase.
    function automatic int mid_high(input logic [7:0] seed, input logic [3:0] mn, input int k);
        logic [7:0] lf;
        int         m, t, h, l;
        lf = (seed == 8'h00) ? 8'h01 : seed;
        m  = (mn == 4'd0) ? 1 : int'(mn);
        t  = 1;
        for (int i = 1; i <= k; i++) begin
            h  = m + int'(lf[2:0]);
            lf = step8(lf);
            if (i == k) return t + h / 2;
            l  = m + int'(lf[2:0]);
            lf = step8(lf);
            t  = t + h + l;
        end
        return t;
    endfunction

    task automatic run_burst(input string name, input logic [7:0] seed, input logic [3:0] mn,
                             input logic [15:0] num, input int stop_at, input int restart_at,
                             input int rst_at);
        logic [7:0]  lf;
        logic [15:0] cnt;
        int          m, len, edge_e;
        bit          fin;
        exp_t        e;

        exp_q.delete();
        lf  = (seed == 8'h00) ? 8'h01 : seed;
        m   = (mn == 4'd0) ? 1 : int'(mn);
        cnt = 16'd0;
        e = '{clk: 1'b0, busy: 1'b1, done: 1'b0, cnt: 16'd0, lfsr: model_lfsr};
        exp_q.push_back(e);
        fin = 1'b0;
        while (!fin && exp_q.size() < 4000) begin
            len = m + int'(lf[2:0]);
            lf  = step8(lf);
            e = '{clk: 1'b1, busy: 1'b1, done: 1'b0, cnt: cnt, lfsr: lf};
            repeat (len) exp_q.push_back(e);
            len = m + int'(lf[2:0]);
            lf  = step8(lf);
            e = '{clk: 1'b0, busy: 1'b1, done: 1'b0, cnt: cnt, lfsr: lf};
            repeat (len) exp_q.push_back(e);
            edge_e = exp_q.size();
            cnt++;
            fin = ((num != 16'd0) && (cnt == num)) || ((stop_at >= 1) && (stop_at <= edge_e));
        end
        e = '{clk: 1'b0, busy: 1'b1, done: 1'b1, cnt: cnt, lfsr: lf};
        exp_q.push_back(e);
        e = '{clk: 1'b0, busy: 1'b0, done: 1'b0, cnt: cnt, lfsr: lf};
        exp_q.push_back(e);

        @(posedge i_clk); #1;
        i_seed       = seed;
        i_min_phase  = mn;
        i_num_cycles = num;
        i_start      = 1'b1;
        i_stop       = (stop_at == 0);
        @(posedge i_clk); #1;
        i_start      = 1'b0;
        i_stop       = 1'b0;
        i_seed       = 8'($urandom);
        i_min_phase  = 4'($urandom);
        i_num_cycles = 16'($urandom);

        for (int t = 0; t < exp_q.size(); t++) begin
            if (t == rst_at) begin
                #2 i_rstn = 1'b0;
                #1;
                check_val($sformatf("%s rst_clk", name), 32'(o_rnd_clk), 32'd0);
                check_val($sformatf("%s rst_busy", name), 32'(o_busy), 32'd0);
                check_val($sformatf("%s rst_done", name), 32'(o_done), 32'd0);
                @(posedge i_clk); #1;
                check_val($sformatf("%s rst_done2", name), 32'(o_done), 32'd0);
                check_val($sformatf("%s rst_lfsr", name), 32'(o_lfsr), 32'h01);
                i_rstn     = 1'b1;
                model_lfsr = 8'h01;
                $display("burst %s seed=%02h min=%0d num=%0d reset at period %0d", name, seed, mn, num, t);
                return;
            end
            check_val($sformatf("%s clk t%0d", name, t), 32'(o_rnd_clk), 32'(exp_q[t].clk));
            check_val($sformatf("%s busy t%0d", name, t), 32'(o_busy), 32'(exp_q[t].busy));
            check_val($sformatf("%s done t%0d", name, t), 32'(o_done), 32'(exp_q[t].done));
            check_val($sformatf("%s cnt t%0d", name, t), 32'(o_cycle_cnt), 32'(exp_q[t].cnt));
            check_val($sformatf("%s lfsr t%0d", name, t), 32'(o_lfsr), 32'(exp_q[t].lfsr));
            check_val($sformatf("%s lfsr_nz t%0d", name, t), 32'(o_lfsr != 8'h00), 32'd1);
            i_stop  = (t == stop_at - 1);
            i_start = (t == restart_at);
            @(posedge i_clk); #1;
        end
        i_start    = 1'b0;
        i_stop     = 1'b0;
        model_lfsr = lf;
        $display("burst %s seed=%02h min=%0d num=%0d periods=%0d cycles=%0d", name, seed, mn, num,
                 exp_q.size(), cnt);
    endtask

    initial begin
        logic [7:0]  r_seed;
        logic [3:0]  r_min;
        logic [15:0] r_num;
        int          r_stop;

        i_rstn       = 1'b0;
        i_start      = 1'b0;
        i_stop       = 1'b0;
        i_seed       = 8'h00;
        i_num_cycles = 16'd0;
        i_min_phase  = 4'd0;
        model_lfsr   = 8'h01;
        repeat (3) @(posedge i_clk);
        #1 i_rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            // A stop with no burst running must be discarded.
            i_stop = (i == 4);
            check_val($sformatf("idle clk %0d", i), 32'(o_rnd_clk), 32'd0);
            check_val($sformatf("idle busy %0d", i), 32'(o_busy), 32'd0);
            check_val($sformatf("idle done %0d", i), 32'(o_done), 32'd0);
            check_val($sformatf("idle lfsr %0d", i), 32'(o_lfsr), 32'h01);
            check_val($sformatf("idle cnt %0d", i), 32'(o_cycle_cnt), 32'd0);
            @(posedge i_clk); #1;
        end
        i_stop = 1'b0;
        $display("idle 10 cycles after reset");

        run_burst("seed05", 8'h05, 4'd1, 16'd2, -1, -1, -1);
        run_burst("seed00", 8'h00, 4'd0, 16'd1, -1, -1, -1);
        run_burst("stop4", 8'h5A, 4'd1, 16'd0, mid_high(8'h5A, 4'd1, 4), 7, -1);
        run_burst("rst_mid", 8'h05, 4'd1, 16'd2, -1, -1, 3);
        run_burst("after_rst", 8'h05, 4'd1, 16'd2, -1, -1, -1);
        run_burst("start_stop", 8'h05, 4'd1, 16'd2, 0, -1, -1);
        run_burst("freerun", 8'($urandom), 4'd2, 16'd0, 1000, 2, -1);

        for (int k = 0; k < 6; k++) begin
            r_seed = 8'($urandom);
            r_min  = 4'($urandom_range(0, 15));
            r_num  = 16'($urandom_range(0, 4));
            if (r_num == 16'd0)
                r_stop = int'($urandom_range(1, 120));
            else
                r_stop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 150)) : -1;
            run_burst($sformatf("rand%0d", k), r_seed, r_min, r_num, r_stop,
                      int'($urandom_range(0, 3)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
